seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the 4-digit seven-segment display on the IO shield. It sits directly downstream of the counter/selection logic and takes four hex digit values plus per-digit decimal-point and blank masks. It scans the digits one at a time onto the shared, active-low `io_sel`/`io_seg` pins, with a dead-time gap between digits to suppress ghosting. Inputs are snapshotted once per frame so a digit never changes mid-scan.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_hex_decode.sv | 13 +
 rtl/seg7_scan_driver.sv | 81 ++++++++
 tb/tb_seg7_scan_driver.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display drivers.
// Pattern table is active-high, bit0 = segment a through bit6 = segment g.
package seg7_pkg;

  localparam logic [3:0] SEL_OFF = 4'hF;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [6:0] HEX_PATTERNS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    PH_DEAD,
    PH_ON
  } phase_e;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } snap_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high a..g segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = HEX_PATTERNS[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with per-slot dead time and
// frame-synchronous input snapshot; io_sel/io_seg are active-low and registered.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  output logic [3:0]  io_sel,
  output logic [7:0]  io_seg,
  output logic        frame_tick
);

  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] DEAD_END = 16'(DEAD_CYCLES);

  logic [15:0] cnt;
  logic [1:0]  idx;
  snap_t       snap;
  phase_e      phase;
  logic [3:0]  cur_nib;
  logic [6:0]  cur_pat;
  logic        frame_start;
  logic [3:0]  sel_next;
  logic [7:0]  seg_next;

  seg7_hex_decode u_dec (
    .nibble  (cur_nib),
    .pattern (cur_pat)
  );

  // Gated by rst/en so the pulse only marks a cycle that really captures.
  assign frame_start = en && !rst && (cnt == '0) && (idx == '0);
  assign frame_tick  = frame_start;

  always_comb begin
    phase    = (cnt < DEAD_END) ? PH_DEAD : PH_ON;
    cur_nib  = snap.digits[{idx, 2'b00} +: 4];
    sel_next = SEL_OFF;
    seg_next = SEG_OFF;
    if (phase == PH_ON && !snap.blank[idx]) begin
      sel_next               = ~(4'b0001 << idx);
      seg_next[SEG_G:SEG_A]  = ~cur_pat;
      seg_next[SEG_DP]       = ~snap.dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      snap   <= '{digits: '0, dp: '0, blank: '1};
      io_sel <= SEL_OFF;
      io_seg <= SEG_OFF;
    end else if (!en) begin
      cnt    <= '0;
      idx    <= '0;
      io_sel <= SEL_OFF;
      io_seg <= SEG_OFF;
    end else begin
      if (frame_start) begin
        snap <= '{digits: digits, dp: dp, blank: blank};
      end
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 16'd1;
      end
      io_sel <= sel_next;
      io_seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with SCAN_DIV=8, DEAD_CYCLES=2.
module tb_seg7_scan_driver;

  localparam int SD = 8;
  localparam int DC = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] digits;
  logic [3:0]  dp, blank;
  logic [3:0]  io_sel;
  logic [7:0]  io_seg;
  logic        frame_tick;

  seg7_scan_driver #(.SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits     (digits),
    .dp         (dp),
    .blank      (blank),
    .io_sel     (io_sel),
    .io_seg     (io_seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int vec_count = 0;
  int miscompares = 0;

  logic [6:0] pat_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: position within the run since the last start, plus the
  // snapshot the display should be showing.
  int          m_prev = -1;
  int          m_n = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_bl = 4'hF;

  function automatic logic [11:0] model_out(int pm);
    int slot, pos;
    logic [3:0] sel;
    logic [3:0] nib;
    logic [15:0] sh;
    if (pm < 0) return 12'hFFF;
    slot = (pm / SD) % 4;
    pos  = pm % SD;
    if (pos < DC || m_bl[slot]) return 12'hFFF;
    sel = 4'hF;
    sel[slot] = 1'b0;
    sh  = m_dig >> (4 * slot);
    nib = sh[3:0];
    return {sel, ~m_dp[slot], ~pat_tab[nib]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Called at posedge+1: drive inputs, sample at posedge+2, advance model.
  task automatic cycle(input logic r, input logic e, input logic [15:0] d,
                       input logic [3:0] p, input logic [3:0] b,
                       output logic [3:0] s_o, output logic [7:0] g_o, output logic t_o);
    logic [11:0] exp;
    logic        exp_tick;
    rst = r; en = e; digits = d; dp = p; blank = b;
    #1;
    exp      = model_out(m_prev);
    exp_tick = !r && e && (m_n % FRAME == 0);
    check("outputs", {20'd0, io_sel, io_seg}, {20'd0, exp});
    check("frame_tick", {31'd0, frame_tick}, {31'd0, exp_tick});
    check("sel_onehot", {31'd0, ($countones(~io_sel) <= 1)}, 32'd1);
    s_o = io_sel; g_o = io_seg; t_o = frame_tick;
    if (r) begin
      m_prev = -1; m_n = 0; m_dig = '0; m_dp = '0; m_bl = 4'hF;
    end else if (!e) begin
      m_prev = -1; m_n = 0;
    end else begin
      if (m_n % FRAME == 0) begin
        m_dig = d; m_dp = p; m_bl = b;
      end
      m_prev = m_n;
      m_n++;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] d;
    logic [3:0]  p;
    logic [3:0]  b;
    int          cc;
    logic [3:0]  es;
    logic [7:0]  eg;
  } vec_t;

  vec_t tab [12];

  logic [3:0] s;
  logic [7:0] g;
  logic       t;

  task automatic do_reset();
    repeat (2) cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, s, g, t);
  endtask

  initial begin
    tab[0]  = '{16'h1234, 4'h0, 4'h0,  3, 4'hE, 8'h99};
    tab[1]  = '{16'h1234, 4'h0, 4'h0,  9, 4'hF, 8'hFF};
    tab[2]  = '{16'h1234, 4'h0, 4'h0, 11, 4'hD, 8'hB0};
    tab[3]  = '{16'h8888, 4'h4, 4'h0, 19, 4'hB, 8'h00};
    tab[4]  = '{16'h8888, 4'h4, 4'h0, 27, 4'h7, 8'h80};
    tab[5]  = '{16'h8888, 4'h4, 4'h0,  5, 4'hE, 8'h80};
    tab[6]  = '{16'h0000, 4'h0, 4'h2, 12, 4'hF, 8'hFF};
    tab[7]  = '{16'h0000, 4'h0, 4'h2, 20, 4'hB, 8'hC0};
    tab[8]  = '{16'hABCD, 4'h0, 4'h0, 27, 4'h7, 8'h88};
    tab[9]  = '{16'hFFFF, 4'hF, 4'hF, 19, 4'hF, 8'hFF};
    tab[10] = '{16'h5000, 4'h8, 4'h0, 32, 4'h7, 8'h12};
    tab[11] = '{16'h1234, 4'h0, 4'h0,  8, 4'hE, 8'h99};

    rst = 1'b1; en = 1'b0; digits = '0; dp = '0; blank = '0;
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      do_reset();
      for (int c = 0; c <= tab[i].cc; c++) begin
        cycle(1'b0, 1'b1, tab[i].d, tab[i].p, tab[i].b, s, g, t);
        if (c == 0) check("table_tick0", {31'd0, t}, 32'd1);
        if (c == tab[i].cc) check("table_vec", {20'd0, s, g}, {20'd0, tab[i].es, tab[i].eg});
      end
    end

    // Mid-frame input change must wait for the next frame start.
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      cycle(1'b0, 1'b1, (c >= 12) ? 16'hFFFF : 16'h0000, 4'h0, 4'h0, s, g, t);
      if (c == 27) check("midframe_old", {20'd0, s, g}, {20'd0, 4'h7, 8'hC0});
      if (c == 32) check("midframe_tick", {31'd0, t}, 32'd1);
      if (c == 35) check("midframe_new", {20'd0, s, g}, {20'd0, 4'hE, 8'h8E});
    end

    // Enable dropped for 5 cycles during digit 2.
    do_reset();
    for (int c = 0; c <= 36; c++) begin
      cycle(1'b0, !(c >= 20 && c < 25), 16'h1234, 4'h0, 4'h0, s, g, t);
      if (c == 20) check("endrop_still_lit", {20'd0, s, g}, {20'd0, 4'hB, 8'hA4});
      if (c == 21) check("endrop_dark", {20'd0, s, g}, {20'd0, 4'hF, 8'hFF});
      if (c == 25) check("reenable_tick", {31'd0, t}, 32'd1);
      if (c == 27) check("reenable_dead", {20'd0, s, g}, {20'd0, 4'hF, 8'hFF});
      if (c == 28) check("reenable_lit", {20'd0, s, g}, {20'd0, 4'hE, 8'h99});
    end

    // Reset with en low in the middle of a lit slot.
    do_reset();
    for (int c = 0; c < 13; c++) cycle(1'b0, 1'b1, 16'h1234, 4'h0, 4'h0, s, g, t);
    cycle(1'b1, 1'b0, 16'h1234, 4'h0, 4'h0, s, g, t);
    check("rst_midslot_before", {20'd0, s, g}, {20'd0, 4'hD, 8'hB0});
    cycle(1'b0, 1'b0, 16'h1234, 4'h0, 4'h0, s, g, t);
    check("rst_midslot_after", {20'd0, s, g}, {20'd0, 4'hF, 8'hFF});

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 63) != 0),
            16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
            s, g, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
